// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite types and helpers: response codes, read FSM states, byte-strobe merge.
package axi4_lite_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rd_state_t;

  localparam int unsigned MaxDataWidth = 64;
  localparam int unsigned MaxStrbWidth = MaxDataWidth / 8;

  // Sized for the widest bus; narrower callers zero-extend and truncate.
  function automatic logic [MaxDataWidth-1:0] strb_merge(
    input logic [MaxDataWidth-1:0] old,
    input logic [MaxDataWidth-1:0] wdata,
    input logic [MaxStrbWidth-1:0] wstrb
  );
    logic [MaxDataWidth-1:0] res;
    res = old;
    for (int b = 0; b < int'(MaxStrbWidth); b++) begin
      if (wstrb[b]) res[b*8 +: 8] = wdata[b*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/axi4_lite_reg_slave.sv
// AXI4-Lite register bank: NUM_REGS word registers with WSTRB merge and flat register export.
// Optional AXIL_PROT_CHECK_EN rejects non-secure accesses to indices >= SECURE_BASE.
module axi4_lite_reg_slave
  import axi4_lite_pkg::*;
#(
  parameter int unsigned DATAWIDTH   = 32,
  parameter int unsigned ADDRWIDTH   = 32,
  parameter int unsigned NUM_REGS    = 16,
  parameter int unsigned SECURE_BASE = 8
) (
  input  logic                          aclk,
  input  logic                          aresetn,
  input  logic [ADDRWIDTH-1:0]          awaddr,
  input  logic [2:0]                    awprot,
  input  logic                          awvalid,
  output logic                          awready,
  input  logic [DATAWIDTH-1:0]          wdata,
  input  logic [DATAWIDTH/8-1:0]        wstrb,
  input  logic                          wvalid,
  output logic                          wready,
  output logic [1:0]                    bresp,
  output logic                          bvalid,
  input  logic                          bready,
  input  logic [ADDRWIDTH-1:0]          araddr,
  input  logic [2:0]                    arprot,
  input  logic                          arvalid,
  output logic                          arready,
  output logic [DATAWIDTH-1:0]          rdata,
  output logic [1:0]                    rresp,
  output logic                          rvalid,
  input  logic                          rready,
  output logic [NUM_REGS*DATAWIDTH-1:0] regs_o
);

  localparam int unsigned StrbWidth  = DATAWIDTH / 8;
  localparam int unsigned Lsb        = $clog2(StrbWidth);
  localparam int unsigned IdxWidth   = $clog2(NUM_REGS);
  localparam int unsigned RangeBytes = NUM_REGS * StrbWidth;

  logic [DATAWIDTH-1:0] regs_q [NUM_REGS];

  logic                 aw_hold_q, aw_hold_d, w_hold_q, w_hold_d;
  logic                 bvalid_q, bvalid_d, awready_q, wready_q;
  logic [ADDRWIDTH-1:0] aw_addr_q;
  logic [DATAWIDTH-1:0] w_data_q;
  logic [StrbWidth-1:0] w_strb_q;
  resp_t                bresp_q, wr_resp, rd_resp;
  logic                 aw_fire, w_fire, commit;
  logic [IdxWidth-1:0]  wr_idx, rd_idx;
  logic [MaxDataWidth-1:0] merged;

  rd_state_t            rd_state_q;
  logic                 arready_q, rvalid_q;
  logic [DATAWIDTH-1:0] rdata_q;
  resp_t                rresp_q;

`ifdef AXIL_PROT_CHECK_EN
  logic [2:0] aw_prot_q;
`else
  localparam int unsigned unused_secure_base = SECURE_BASE;
`endif

  assign aw_fire = awvalid && awready_q;
  assign w_fire  = wvalid && wready_q;
  assign commit  = aw_hold_q && w_hold_q;
  assign wr_idx  = aw_addr_q[Lsb +: IdxWidth];
  assign rd_idx  = araddr[Lsb +: IdxWidth];

  always_comb begin
    wr_resp = (64'(aw_addr_q) >= 64'(RangeBytes)) ? SLVERR : OKAY;
    rd_resp = (64'(araddr) >= 64'(RangeBytes)) ? SLVERR : OKAY;
`ifdef AXIL_PROT_CHECK_EN
    if (aw_prot_q[1] && (32'(wr_idx) >= SECURE_BASE)) wr_resp = SLVERR;
    if (arprot[1] && (32'(rd_idx) >= SECURE_BASE)) rd_resp = SLVERR;
`endif
    merged = strb_merge(MaxDataWidth'(regs_q[wr_idx]), MaxDataWidth'(w_data_q),
                        MaxStrbWidth'(w_strb_q));
  end

  always_comb begin
    aw_hold_d = aw_hold_q;
    w_hold_d  = w_hold_q;
    bvalid_d  = bvalid_q;
    if (aw_fire) aw_hold_d = 1'b1;
    if (w_fire) w_hold_d = 1'b1;
    if (commit) begin
      aw_hold_d = 1'b0;
      w_hold_d  = 1'b0;
      bvalid_d  = 1'b1;
    end
    if (bvalid_q && bready) bvalid_d = 1'b0;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      aw_hold_q <= 1'b0;
      w_hold_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= OKAY;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
`ifdef AXIL_PROT_CHECK_EN
      aw_prot_q <= '0;
`endif
      for (int i = 0; i < int'(NUM_REGS); i++) regs_q[i] <= '0;
    end else begin
      aw_hold_q <= aw_hold_d;
      w_hold_q  <= w_hold_d;
      bvalid_q  <= bvalid_d;
      // Readies are registered copies of the next hold/response state.
      awready_q <= !aw_hold_d && !bvalid_d;
      wready_q  <= !w_hold_d && !bvalid_d;
      if (aw_fire) begin
        aw_addr_q <= awaddr;
`ifdef AXIL_PROT_CHECK_EN
        aw_prot_q <= awprot;
`endif
      end
      if (w_fire) begin
        w_data_q <= wdata;
        w_strb_q <= wstrb;
      end
      if (commit) begin
        bresp_q <= wr_resp;
        if (wr_resp == OKAY) regs_q[wr_idx] <= merged[DATAWIDTH-1:0];
      end
    end
  end

  // A read landing on the same edge as a write commit sees the pre-write value.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rd_state_q <= R_IDLE;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= OKAY;
    end else begin
      unique case (rd_state_q)
        R_IDLE: begin
          if (arvalid && arready_q) begin
            rdata_q    <= (rd_resp == OKAY) ? regs_q[rd_idx] : '0;
            rresp_q    <= rd_resp;
            rvalid_q   <= 1'b1;
            arready_q  <= 1'b0;
            rd_state_q <= R_DATA;
          end else begin
            arready_q <= 1'b1;
          end
        end
        R_DATA: begin
          if (rready) begin
            rvalid_q   <= 1'b0;
            arready_q  <= 1'b1;
            rd_state_q <= R_IDLE;
          end
        end
        default: rd_state_q <= R_IDLE;
      endcase
    end
  end

  assign awready = awready_q;
  assign wready  = wready_q;
  assign bvalid  = bvalid_q;
  assign bresp   = bresp_q;
  assign arready = arready_q;
  assign rvalid  = rvalid_q;
  assign rdata   = rdata_q;
  assign rresp   = rresp_q;

  for (genvar i = 0; i < int'(NUM_REGS); i++) begin : g_regs_out
    assign regs_o[i*DATAWIDTH +: DATAWIDTH] = regs_q[i];
  end

  logic unused_sig;
  assign unused_sig = ^{awprot, arprot, merged};

endmodule

// File: tb/tb_axi4_lite_reg_slave.sv
// Randomised self-checking bench for axi4_lite_reg_slave against a byte-level register model.
module tb_axi4_lite_reg_slave;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int NR = 16;

  logic            aclk = 1'b0;
  logic            aresetn = 1'b0;
  logic [AW-1:0]   awaddr = '0;
  logic [2:0]      awprot = '0;
  logic            awvalid = 1'b0;
  logic            awready;
  logic [DW-1:0]   wdata = '0;
  logic [DW/8-1:0] wstrb = '0;
  logic            wvalid = 1'b0;
  logic            wready;
  logic [1:0]      bresp;
  logic            bvalid;
  logic            bready = 1'b0;
  logic [AW-1:0]   araddr = '0;
  logic [2:0]      arprot = '0;
  logic            arvalid = 1'b0;
  logic            arready;
  logic [DW-1:0]   rdata;
  logic [1:0]      rresp;
  logic            rvalid;
  logic            rready = 1'b0;
  logic [NR*DW-1:0] regs_o;

  axi4_lite_reg_slave dut (
    .aclk(aclk), .aresetn(aresetn),
    .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .regs_o(regs_o)
  );

  always #5 aclk = ~aclk;

  logic [DW-1:0] model [NR];
  int tests_run = 0;
  int tests_failed = 0;

  function automatic logic [NR*DW-1:0] model_flat();
    logic [NR*DW-1:0] f;
    for (int i = 0; i < NR; i++) f[i*DW +: DW] = model[i];
    return f;
  endfunction

  function automatic int model_idx(input logic [AW-1:0] a);
    return int'((a / 4) % NR);
  endfunction

  function automatic bit model_ok(input logic [AW-1:0] a, input logic [2:0] prot);
    bit ok;
    ok = (a < NR * 4);
`ifdef AXIL_PROT_CHECK_EN
    if (prot[1] && model_idx(a) >= 8) ok = 1'b0;
`else
    if (prot === 3'bxxx) ok = 1'b0;
`endif
    return ok;
  endfunction

  task automatic model_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                             input logic [3:0] s, input logic [2:0] prot);
    if (model_ok(a, prot)) begin
      for (int b = 0; b < 4; b++) if (s[b]) model[model_idx(a)][b*8 +: 8] = d[b*8 +: 8];
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < NR; i++) model[i] = '0;
  endtask

  task automatic axi_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] s,
                           input logic [2:0] prot, output logic [1:0] resp, output bit to);
    bit a_f, w_f;
    @(negedge aclk);
    awaddr = a; awprot = prot; awvalid = 1'b1;
    wdata = d; wstrb = s; wvalid = 1'b1; bready = 1'b1;
    to = 1'b1; resp = 2'bxx;
    for (int cyc = 0; cyc < 50; cyc++) begin
      if (bvalid) begin
        resp = bresp; to = 1'b0;
        @(negedge aclk);
        break;
      end
      a_f = awvalid && awready;
      w_f = wvalid && wready;
      @(negedge aclk);
      if (a_f) awvalid = 1'b0;
      if (w_f) wvalid = 1'b0;
    end
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0;
  endtask

  task automatic axi_read(input logic [AW-1:0] a, input logic [2:0] prot,
                          output logic [DW-1:0] d, output logic [1:0] resp, output bit to);
    bit a_f;
    @(negedge aclk);
    araddr = a; arprot = prot; arvalid = 1'b1; rready = 1'b1;
    to = 1'b1; d = 'x; resp = 2'bxx;
    for (int cyc = 0; cyc < 50; cyc++) begin
      if (rvalid) begin
        d = rdata; resp = rresp; to = 1'b0;
        @(negedge aclk);
        break;
      end
      a_f = arvalid && arready;
      @(negedge aclk);
      if (a_f) arvalid = 1'b0;
    end
    arvalid = 1'b0; rready = 1'b0;
  endtask

  task automatic test_reset();
    model_clear();
    repeat (3) @(negedge aclk);
    tests_run++;
    if ({awready, wready, arready} !== 3'b000) begin
      tests_failed++; $display("FAIL reset_ready: got %b expected 000", {awready, wready, arready});
    end
    tests_run++;
    if ({bvalid, rvalid, bresp, rresp} !== 6'b0) begin
      tests_failed++; $display("FAIL reset_resp: got %b expected 0", {bvalid, rvalid, bresp, rresp});
    end
    tests_run++;
    if (rdata !== '0 || regs_o !== '0) begin
      tests_failed++; $display("FAIL reset_data: rdata %h regs nonzero=%0b", rdata, |regs_o);
    end
    aresetn = 1'b1;
    @(negedge aclk);
    tests_run++;
    if ({awready, wready, arready} !== 3'b111) begin
      tests_failed++; $display("FAIL reset_release: got %b expected 111", {awready, wready, arready});
    end
  endtask

  task automatic test_write_same_cycle();
    @(negedge aclk);
    awaddr = 'h4; awprot = 0; awvalid = 1; wdata = 32'hDEADBEEF; wstrb = 4'hF; wvalid = 1;
    @(negedge aclk);
    awvalid = 0; wvalid = 0;
    tests_run++;
    if (bvalid !== 1'b0) begin
      tests_failed++; $display("FAIL same_cycle_early_b: got %b expected 0", bvalid);
    end
    @(negedge aclk);
    model_write('h4, 32'hDEADBEEF, 4'hF, 3'b000);
    tests_run++;
    if (bvalid !== 1'b1 || bresp !== 2'b00) begin
      tests_failed++; $display("FAIL same_cycle_b: got %b/%b expected 1/00", bvalid, bresp);
    end
    tests_run++;
    if (regs_o !== model_flat() || regs_o[DW +: DW] !== 32'hDEADBEEF) begin
      tests_failed++; $display("FAIL same_cycle_reg1: got %h expected deadbeef", regs_o[DW +: DW]);
    end
    bready = 1;
    @(negedge aclk);
    bready = 0;
    tests_run++;
    if (bvalid !== 1'b0) begin
      tests_failed++; $display("FAIL same_cycle_b_clear: got %b expected 0", bvalid);
    end
  endtask

  task automatic test_w_before_aw();
    logic [1:0] r;
    bit to;
    bit extra_b;
    axi_write('h8, 32'hFFFFFFFF, 4'hF, 3'b000, r, to);
    model_write('h8, 32'hFFFFFFFF, 4'hF, 3'b000);
    tests_run++;
    if (to || r !== 2'b00) begin
      tests_failed++; $display("FAIL prefill_resp: got %b to=%0b expected 00", r, to);
    end
    @(negedge aclk);
    wdata = 32'h11223344; wstrb = 4'b0101; wvalid = 1;
    @(negedge aclk);
    wvalid = 0;
    repeat (2) begin
      @(negedge aclk);
      tests_run++;
      if (wready !== 1'b0 || bvalid !== 1'b0) begin
        tests_failed++; $display("FAIL w_held: wready %b bvalid %b expected 0 0", wready, bvalid);
      end
    end
    awaddr = 'h8; awprot = 0; awvalid = 1;
    @(negedge aclk);
    awvalid = 0;
    @(negedge aclk);
    model_write('h8, 32'h11223344, 4'b0101, 3'b000);
    tests_run++;
    if (bvalid !== 1'b1 || bresp !== 2'b00) begin
      tests_failed++; $display("FAIL w_first_b: got %b/%b expected 1/00", bvalid, bresp);
    end
    tests_run++;
    if (regs_o !== model_flat() || regs_o[2*DW +: DW] !== 32'hFF22FF44) begin
      tests_failed++; $display("FAIL w_first_reg2: got %h expected ff22ff44", regs_o[2*DW +: DW]);
    end
    bready = 1;
    @(negedge aclk);
    bready = 0;
    extra_b = 0;
    repeat (3) begin
      @(negedge aclk);
      if (bvalid) extra_b = 1;
    end
    tests_run++;
    if (extra_b) begin
      tests_failed++; $display("FAIL w_first_single_b: got extra B expected none");
    end
  endtask

  task automatic test_b_backpressure();
    logic [DW-1:0] d;
    bit seen;
    d = $urandom;
    @(negedge aclk);
    awaddr = 'hC; awprot = 0; awvalid = 1; wdata = d; wstrb = 4'hF; wvalid = 1; bready = 0;
    @(negedge aclk);
    awvalid = 0; wvalid = 0;
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      if (bvalid) seen = 1;
      else @(negedge aclk);
    end
    model_write('hC, d, 4'hF, 3'b000);
    tests_run++;
    if (!seen) begin
      tests_failed++; $display("FAIL bp_b_timeout: bvalid %b expected 1", bvalid);
    end
    awaddr = 'h10; awvalid = 1; wdata = ~d; wvalid = 1;
    for (int i = 0; i < 5; i++) begin
      tests_run++;
      if (bvalid !== 1'b1 || bresp !== 2'b00 || awready !== 1'b0 || wready !== 1'b0) begin
        tests_failed++;
        $display("FAIL bp_stable: bvalid %b bresp %b awready %b wready %b expected 1 00 0 0",
                 bvalid, bresp, awready, wready);
      end
      @(negedge aclk);
    end
    awvalid = 0; wvalid = 0; bready = 1;
    @(negedge aclk);
    bready = 0;
    repeat (2) @(negedge aclk);
    tests_run++;
    if (regs_o !== model_flat() || bvalid !== 1'b0) begin
      tests_failed++; $display("FAIL bp_regs: reg3 %h reg4 %h bvalid %b expected %h %h 0",
                               regs_o[3*DW +: DW], regs_o[4*DW +: DW], bvalid, model[3], model[4]);
    end
  endtask

  task automatic test_read_backpressure();
    @(negedge aclk);
    araddr = 'h4; arprot = 0; arvalid = 1; rready = 0;
    @(negedge aclk);
    arvalid = 0;
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if (rvalid !== 1'b1 || rdata !== model[1] || rresp !== 2'b00 || arready !== 1'b0) begin
        tests_failed++;
        $display("FAIL rd_bp: rvalid %b rdata %h rresp %b arready %b expected 1 %h 00 0",
                 rvalid, rdata, rresp, arready, model[1]);
      end
      @(negedge aclk);
    end
    rready = 1;
    @(negedge aclk);
    rready = 0;
    tests_run++;
    if (rvalid !== 1'b0) begin
      tests_failed++; $display("FAIL rd_bp_clear: rvalid %b expected 0", rvalid);
    end
    @(negedge aclk);
    tests_run++;
    if (arready !== 1'b1) begin
      tests_failed++; $display("FAIL rd_bp_arready: got %b expected 1", arready);
    end
  endtask

  task automatic test_out_of_range();
    logic [1:0] r;
    logic [DW-1:0] d;
    bit to;
    axi_write('h40, 32'hCAFEF00D, 4'hF, 3'b000, r, to);
    tests_run++;
    if (to || r !== 2'b10 || regs_o !== model_flat()) begin
      tests_failed++; $display("FAIL oor_write: resp %b to=%0b expected 10, regs unchanged", r, to);
    end
    axi_read('h40, 3'b000, d, r, to);
    tests_run++;
    if (to || r !== 2'b10 || d !== '0) begin
      tests_failed++; $display("FAIL oor_read: resp %b data %h expected 10 0", r, d);
    end
  endtask

  task automatic test_prot();
`ifdef AXIL_PROT_CHECK_EN
    logic [1:0] r;
    bit to;
    axi_write('h20, 32'h5A5A5A5A, 4'hF, 3'b010, r, to);
    tests_run++;
    if (to || r !== 2'b10 || regs_o !== model_flat()) begin
      tests_failed++; $display("FAIL prot_ns: resp %b reg8 %h expected 10 %h",
                               r, regs_o[8*DW +: DW], model[8]);
    end
    axi_write('h20, 32'h5A5A5A5A, 4'hF, 3'b000, r, to);
    model_write('h20, 32'h5A5A5A5A, 4'hF, 3'b000);
    tests_run++;
    if (to || r !== 2'b00 || regs_o !== model_flat()) begin
      tests_failed++; $display("FAIL prot_sec: resp %b reg8 %h expected 00 %h",
                               r, regs_o[8*DW +: DW], model[8]);
    end
`endif
  endtask

  task automatic test_simul_rw();
    logic [DW-1:0] old, nw;
    logic [1:0] r;
    bit to;
    axi_write('h14, $urandom, 4'hF, 3'b000, r, to);
    model_write('h14, wdata, 4'hF, 3'b000);
    old = model[5];
    nw = ~old;
    @(negedge aclk);
    awaddr = 'h14; awprot = 0; awvalid = 1; wdata = nw; wstrb = 4'hF; wvalid = 1;
    @(negedge aclk);
    awvalid = 0; wvalid = 0;
    araddr = 'h14; arprot = 0; arvalid = 1;
    @(negedge aclk);
    arvalid = 0;
    model_write('h14, nw, 4'hF, 3'b000);
    tests_run++;
    if (rvalid !== 1'b1 || rdata !== old || bvalid !== 1'b1) begin
      tests_failed++; $display("FAIL simul_rw: rvalid %b rdata %h bvalid %b expected 1 %h 1",
                               rvalid, rdata, bvalid, old);
    end
    bready = 1; rready = 1;
    @(negedge aclk);
    bready = 0; rready = 0;
    tests_run++;
    if (regs_o !== model_flat()) begin
      tests_failed++; $display("FAIL simul_rw_reg: got %h expected %h", regs_o[5*DW +: DW], nw);
    end
  endtask

  task automatic test_random();
    logic [AW-1:0] a;
    logic [DW-1:0] d, rd;
    logic [3:0] s;
    logic [1:0] r, exp_r;
    bit to;
    for (int n = 0; n < 30; n++) begin
      a = AW'($urandom_range(0, 'h4F));
      d = $urandom;
      s = 4'($urandom_range(0, 15));
      axi_write(a, d, s, 3'b000, r, to);
      exp_r = model_ok(a, 3'b000) ? 2'b00 : 2'b10;
      model_write(a, d, s, 3'b000);
      tests_run++;
      if (to || r !== exp_r || regs_o !== model_flat()) begin
        tests_failed++; $display("FAIL rand_write: addr %h resp %b to=%0b expected %b",
                                 a, r, to, exp_r);
      end
      a = AW'($urandom_range(0, 'h4F));
      axi_read(a, 3'b000, rd, r, to);
      exp_r = model_ok(a, 3'b000) ? 2'b00 : 2'b10;
      tests_run++;
      if (to || r !== exp_r || rd !== (model_ok(a, 3'b000) ? model[model_idx(a)] : '0)) begin
        tests_failed++; $display("FAIL rand_read: addr %h data %h resp %b expected resp %b",
                                 a, rd, r, exp_r);
      end
    end
  endtask

  task automatic test_reset_mid();
    @(negedge aclk);
    awaddr = 'h18; awprot = 0; awvalid = 1; wdata = 32'h12345678; wstrb = 4'hF; wvalid = 1;
    bready = 0;
    @(negedge aclk);
    awvalid = 0; wvalid = 0;
    @(negedge aclk);
    tests_run++;
    if (bvalid !== 1'b1) begin
      tests_failed++; $display("FAIL mid_reset_pre: bvalid %b expected 1", bvalid);
    end
    #2 aresetn = 0;
    #1;
    model_clear();
    tests_run++;
    if (bvalid !== 1'b0 || regs_o !== model_flat() || awready !== 1'b0) begin
      tests_failed++; $display("FAIL mid_reset: bvalid %b awready %b regs nonzero=%0b expected 0 0 0",
                               bvalid, awready, |regs_o);
    end
    @(negedge aclk);
    aresetn = 1;
    @(negedge aclk);
    tests_run++;
    if (awready !== 1'b1 || bvalid !== 1'b0) begin
      tests_failed++; $display("FAIL mid_reset_release: awready %b bvalid %b expected 1 0",
                               awready, bvalid);
    end
  endtask

  initial begin
    test_reset();
    test_write_same_cycle();
    test_w_before_aw();
    test_b_backpressure();
    test_read_backpressure();
    test_out_of_range();
    test_prot();
    test_simul_rw();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
